bht_update_ctrl: RTL and testbench

- Sits between the execute stage and the branch history table.
- Checks every resolved branch against the prediction made at fetch, and raises a one-cycle flush with the corrected PC on a mispredict.
- Buffers resolved branches in a small FIFO and drains them into the table's insert port, one update per cycle, under control of a pipeline update-enable.

---
 rtl/bht_update_ctrl.sv | 150 +++++++++++++++
 tb/tb_bht_update_ctrl.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/bht_update_ctrl.sv
// Branch resolve checker and BHT update queue: flags mispredicts with a
// one-cycle flush and drains resolved branches into the table in order.
// Optional statistics counters are enabled by defining BHT_UPD_STATS_EN.
module bht_update_ctrl #(
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned QDEPTH = 4,
  parameter int unsigned CNT_W  = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        ex_valid,
  input  logic                        ex_is_branch,
  input  logic [ADDR_W-1:0]           ex_pc,
  input  logic                        ex_taken,
  input  logic [ADDR_W-1:0]           ex_target,
  input  logic                        ex_pred_taken,
  input  logic [ADDR_W-1:0]           ex_pred_addr,
  input  logic                        upd_en,
  output logic                        ex_stall,
  output logic                        flush,
  output logic [ADDR_W-1:0]           redirect_pc,
  output logic                        bht_is_branch,
  output logic                        bht_is_suc,
  output logic [ADDR_W-1:0]           bht_ins_addr,
  output logic [ADDR_W-1:0]           bht_ins_next_addr,
  output logic [$clog2(QDEPTH):0]     q_count
`ifdef BHT_UPD_STATS_EN
  ,
  output logic [CNT_W-1:0]            stat_branches,
  output logic [CNT_W-1:0]            stat_mispredicts
`endif
);

  localparam int unsigned PTR_W = $clog2(QDEPTH);
  localparam int unsigned QC_W  = PTR_W + 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_PAUSE = 2'd2;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] target;
    logic              taken;
  } entry_t;

  entry_t            mem [QDEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [QC_W-1:0]   count;
  logic [QC_W-1:0]   count_next;
  logic [1:0]        state;
  logic [1:0]        state_next;
  logic              accept;
  logic              mispredict;
  logic              pop;
  logic [ADDR_W-1:0] fix_pc;

  assign ex_stall   = (count == QC_W'(QDEPTH));
  assign accept     = ex_valid & ex_is_branch & ~ex_stall;
  assign mispredict = accept & ((ex_taken != ex_pred_taken) |
                                (ex_taken & (ex_pred_addr != ex_target)));
  assign fix_pc     = ex_taken ? ex_target : ex_pc + ADDR_W'(4);
  assign q_count    = count;

  // Head entry goes to the table only while issuing and the pipeline allows it.
  always_comb begin
    pop = (state == S_ISSUE) & upd_en;
  end

  assign bht_is_branch     = pop;
  assign bht_is_suc        = mem[rd_ptr].taken;
  assign bht_ins_addr      = mem[rd_ptr].pc;
  assign bht_ins_next_addr = mem[rd_ptr].target;

  always_comb begin
    count_next = count;
    case ({accept, pop})
      2'b10:   count_next = count + QC_W'(1);
      2'b01:   count_next = count - QC_W'(1);
      default: count_next = count;
    endcase
  end

  // Drain FSM next-state.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (count_next != '0) state_next = upd_en ? S_ISSUE : S_PAUSE;
      end
      S_ISSUE: begin
        if (!upd_en)               state_next = S_PAUSE;
        else if (count_next == '0) state_next = S_IDLE;
      end
      S_PAUSE: begin
        if (count == '0)  state_next = S_IDLE;
        else if (upd_en)  state_next = S_ISSUE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      state <= state_next;
      count <= count_next;
      if (accept) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)    rd_ptr <= rd_ptr + PTR_W'(1);
    end
  end

  // Storage is not reset; stale entries are unreachable once pointers clear.
  always_ff @(posedge clk) begin
    if (accept && !rst) begin
      mem[wr_ptr] <= '{pc: ex_pc, target: ex_target, taken: ex_taken};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      flush       <= 1'b0;
      redirect_pc <= '0;
    end else begin
      flush <= mispredict;
      if (mispredict) redirect_pc <= fix_pc;
    end
  end

`ifdef BHT_UPD_STATS_EN
  // Saturating event counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_branches    <= '0;
      stat_mispredicts <= '0;
    end else begin
      if (accept && (stat_branches != '1))
        stat_branches <= stat_branches + CNT_W'(1);
      if (mispredict && (stat_mispredicts != '1))
        stat_mispredicts <= stat_mispredicts + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_bht_update_ctrl.sv
// Self-checking bench for bht_update_ctrl: directed plan steps followed by
// random traffic, all compared against a queue-based reference model.
module tb_bht_update_ctrl;

  localparam int unsigned AW = 12;
  localparam int unsigned QD = 4;
  localparam int unsigned CW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          ex_valid, ex_is_branch, ex_taken, ex_pred_taken, upd_en;
  logic [AW-1:0] ex_pc, ex_target, ex_pred_addr;
  logic          ex_stall, flush, bht_is_branch, bht_is_suc;
  logic [AW-1:0] redirect_pc, bht_ins_addr, bht_ins_next_addr;
  logic [2:0]    q_count;
`ifdef BHT_UPD_STATS_EN
  logic [CW-1:0] stat_branches, stat_mispredicts;
`endif

  always #5 clk = ~clk;

  bht_update_ctrl #(.ADDR_W(AW), .QDEPTH(QD), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .ex_valid(ex_valid), .ex_is_branch(ex_is_branch), .ex_pc(ex_pc),
    .ex_taken(ex_taken), .ex_target(ex_target),
    .ex_pred_taken(ex_pred_taken), .ex_pred_addr(ex_pred_addr),
    .upd_en(upd_en), .ex_stall(ex_stall), .flush(flush),
    .redirect_pc(redirect_pc), .bht_is_branch(bht_is_branch),
    .bht_is_suc(bht_is_suc), .bht_ins_addr(bht_ins_addr),
    .bht_ins_next_addr(bht_ins_next_addr), .q_count(q_count)
`ifdef BHT_UPD_STATS_EN
    , .stat_branches(stat_branches), .stat_mispredicts(stat_mispredicts)
`endif
  );

  typedef struct {
    int pc;
    int tgt;
    int tk;
  } ent_t;

  // Reference model state
  ent_t q[$];
  bit   armed;          // previous cycle had upd_en with work pending
  int   exp_flush;
  int   exp_redir;
  int   exp_nbr, exp_nmis;

  int n_total = 0;
  int n_pass  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // One clock cycle: drive, check at negedge against the model, advance model.
  task automatic step(input bit r, input bit v, input bit b, input int pc,
                      input bit tk, input int tgt, input bit ptk, input int pa,
                      input bit ue);
    bit stall, acc, mis, strobe;
    rst = r; ex_valid = v; ex_is_branch = b; ex_pc = AW'(pc);
    ex_taken = tk; ex_target = AW'(tgt); ex_pred_taken = ptk;
    ex_pred_addr = AW'(pa); upd_en = ue;
    @(negedge clk);
    stall  = (q.size() == QD);
    strobe = armed && ue && (q.size() > 0);
    check("ex_stall", 32'(ex_stall), 32'(stall));
    check("q_count", 32'(q_count), 32'(q.size()));
    check("flush", 32'(flush), 32'(exp_flush));
    check("redirect_pc", 32'(redirect_pc), 32'(exp_redir));
    check("bht_is_branch", 32'(bht_is_branch), 32'(strobe));
    if (strobe) begin
      check("bht_ins_addr", 32'(bht_ins_addr), 32'(q[0].pc));
      check("bht_ins_next_addr", 32'(bht_ins_next_addr), 32'(q[0].tgt));
      check("bht_is_suc", 32'(bht_is_suc), 32'(q[0].tk));
    end
`ifdef BHT_UPD_STATS_EN
    check("stat_branches", 32'(stat_branches), 32'(exp_nbr));
    check("stat_mispredicts", 32'(stat_mispredicts), 32'(exp_nmis));
`endif
    if (r) begin
      q.delete(); armed = 0; exp_flush = 0; exp_redir = 0;
      exp_nbr = 0; exp_nmis = 0;
    end else begin
      acc = v && b && !stall;
      mis = acc && ((tk != ptk) || (tk && (pa != tgt)));
      if (strobe) void'(q.pop_front());
      if (acc) q.push_back('{pc: pc, tgt: tgt, tk: int'(tk)});
      armed = ue && (q.size() > 0);
      exp_flush = int'(mis);
      if (mis) exp_redir = tk ? tgt : ((pc + 4) % 4096);
      if (acc && exp_nbr < 65535) exp_nbr++;
      if (mis && exp_nmis < 65535) exp_nmis++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic br(input int pc, input bit tk, input int tgt, input bit ptk,
                    input int pa, input bit ue);
    step(0, 1, 1, pc, tk, tgt, ptk, pa, ue);
  endtask

  task automatic idle(input bit ue);
    step(0, 0, 0, 0, 0, 0, 0, 0, ue);
  endtask

  initial begin
    int pc, tgt, pa;
    bit tk, ptk;
    rst = 1; ex_valid = 0; ex_is_branch = 0; ex_pc = '0; ex_taken = 0;
    ex_target = '0; ex_pred_taken = 0; ex_pred_addr = '0; upd_en = 0;
    q.delete(); armed = 0; exp_flush = 0; exp_redir = 0; exp_nbr = 0; exp_nmis = 0;
    @(posedge clk); #1;
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(0);

    // Correct prediction
    br(12'h010, 1, 12'h040, 1, 12'h040, 1);
    check("corr_flush", 32'(flush), 32'd0);
    idle(1);
    check("corr_qcount", 32'(q_count), 32'd0);

    // Not-taken mispredict at address wrap
    br(12'hFFC, 0, 12'h100, 1, 12'h100, 1);
    check("wrap_flush", 32'(flush), 32'd1);
    check("wrap_redirect", 32'(redirect_pc), 32'h000);
    idle(1);
    check("wrap_flush_end", 32'(flush), 32'd0);

    // Wrong target, then a back-to-back mispredict
    br(12'h200, 1, 12'h080, 1, 12'h084, 1);
    check("tgt_redirect", 32'(redirect_pc), 32'h080);
    br(12'h300, 1, 12'h500, 0, 12'h000, 1);
    check("b2b_flush", 32'(flush), 32'd1);
    check("b2b_redirect", 32'(redirect_pc), 32'h500);
    idle(1); idle(1);

    // Fill with updates disabled; fifth push must be dropped
    for (int i = 0; i < 5; i++) br(12'h400 + 4 * i, i % 2, 12'h600 + 4 * i, i % 2, 12'h600 + 4 * i, 0);
    check("full_stall", 32'(ex_stall), 32'd1);
    for (int i = 0; i < 6; i++) idle(1);

    // Pause mid-drain
    for (int i = 0; i < 3; i++) br(12'h700 + 4 * i, 1, 12'h7F0, 1, 12'h7F0, 0);
    idle(1); idle(1); idle(0); idle(0);
    for (int i = 0; i < 4; i++) idle(1);

    // Reset mid-operation with a mispredict on the input
    for (int i = 0; i < 3; i++) br(12'h800 + 4 * i, 0, 12'h900, 0, 12'h900, 0);
    step(1, 1, 1, 12'hA00, 1, 12'hA40, 0, 12'h000, 1);
    check("rst_qcount", 32'(q_count), 32'd0);
    check("rst_flush", 32'(flush), 32'd0);
    check("rst_redirect", 32'(redirect_pc), 32'd0);
`ifdef BHT_UPD_STATS_EN
    check("rst_stat_br", 32'(stat_branches), 32'd0);
    check("rst_stat_mis", 32'(stat_mispredicts), 32'd0);
`endif
    idle(1);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      pc  = int'($urandom_range(0, 4095));
      tgt = int'($urandom_range(0, 4095));
      tk  = 1'($urandom_range(0, 1));
      ptk = ($urandom_range(0, 3) == 0) ? !tk : tk;
      pa  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 4095)) : tgt;
      step($urandom_range(0, 49) == 0, 1'($urandom_range(0, 3) != 0),
           1'($urandom_range(0, 4) != 0), pc, tk, tgt, ptk, pa,
           $urandom_range(0, 9) < 6);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
